btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce_pkg.sv | 14 +
 rtl/btn_debounce_sync_2ff.sv | 24 ++
 rtl/btn_debounce.sv | 106 ++++++++++
 tb/tb_btn_debounce.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// rtl/btn_debounce_pkg.sv - shared input-block constants: FSM encodings and default timings
package btn_debounce_pkg;

    // Debounce FSM encodings, shared with other input blocks
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // 10 ms debounce and 1 s long-press at a 100 MHz clock
    localparam int DEF_DEBOUNCE_CNT = 1_000_000;
    localparam int DEF_LONG_CNT     = 100_000_000;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// rtl/btn_debounce_sync_2ff.sv - two-flop synchronizer for an asynchronous pin
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    // Resetting to the idle pin level keeps reset from looking like an edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= RST_VAL;
            q_o  <= RST_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button debouncer with press/release/long-press pulses
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int DB_WIDTH     = 20,
    parameter int LONG_CNT     = DEF_LONG_CNT,
    parameter int LONG_WIDTH   = 27,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam logic [DB_WIDTH-1:0]   DB_LAST   = DB_WIDTH'(DEBOUNCE_CNT - 1);
    localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_CNT - 1);

    logic                  sync_q;
    logic                  s;
    logic [1:0]            state;
    logic [DB_WIDTH-1:0]   db_cnt;
    logic [LONG_WIDTH-1:0] hold_cnt;
    logic                  long_done;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (btn_i),
        .q_o   (sync_q)
    );

    // Normalise polarity so s = 1 always means pressed
    assign s = sync_q ^ ACTIVE_LOW;

    // Debounce FSM; pulses default low and are raised only on accepted events
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s) begin
                        state  <= ST_PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s) begin
                        state <= ST_IDLE;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= ST_PRESSED;
                        level_o   <= 1'b1;
                        press_o   <= 1'b1;
                        hold_cnt  <= '0;
                        long_done <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // long_done survives release bounces so a held press reports once
                    if (hold_cnt == LONG_LAST && !long_done) begin
                        long_o    <= 1'b1;
                        long_done <= 1'b1;
                    end
                    if (!s) begin
                        state  <= ST_RELEASE_WAIT;
                        db_cnt <= '0;
                    end else if (hold_cnt != LONG_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (s) begin
                        state <= ST_PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= ST_IDLE;
                        level_o   <= 1'b0;
                        release_o <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - randomized self-checking bench for btn_debounce
module tb_btn_debounce;

    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic btn_n = 1'b1;

    logic level, press, rel, lng;
    logic level_al, press_al, rel_al, lng_al;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    btn_debounce #(
        .DEBOUNCE_CNT (D), .DB_WIDTH (3), .LONG_CNT (L), .LONG_WIDTH (5), .ACTIVE_LOW (1'b0)
    ) dut (
        .clk_i (clk), .rst_i (rst), .btn_i (btn),
        .level_o (level), .press_o (press), .release_o (rel), .long_o (lng)
    );

    btn_debounce #(
        .DEBOUNCE_CNT (D), .DB_WIDTH (3), .LONG_CNT (L), .LONG_WIDTH (5), .ACTIVE_LOW (1'b1)
    ) dut_al (
        .clk_i (clk), .rst_i (rst), .btn_i (btn_n),
        .level_o (level_al), .press_o (press_al), .release_o (rel_al), .long_o (lng_al)
    );

    // Reference: a level flips once the synchronized input has disagreed with it
    // for D+1 consecutive clocks; hold time counts clocks pressed without a bounce
    typedef struct packed {
        logic s1, s2, prev_s, level, done, press, rel, lng;
        int   run;
        int   hold;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t cur, logic b);
        model_t n;
        logic   s;
        n = cur;
        s = cur.s2;
        n.press = 1'b0;
        n.rel   = 1'b0;
        n.lng   = 1'b0;
        if (cur.level && cur.prev_s && cur.hold >= L - 1 && !cur.done) begin
            n.lng  = 1'b1;
            n.done = 1'b1;
        end
        if (cur.level && s && cur.prev_s && cur.hold < L - 1)
            n.hold = cur.hold + 1;
        n.run = (s != cur.level) ? cur.run + 1 : 0;
        if (n.run == D + 1) begin
            n.level = s;
            n.run   = 0;
            if (s) begin
                n.press = 1'b1;
                n.hold  = 0;
                n.done  = 1'b0;
            end else begin
                n.rel = 1'b1;
            end
        end
        n.prev_s = s;
        n.s2     = cur.s1;
        n.s1     = b;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_next(m, btn);
    end

    // Scoreboard: both polarities must track the reference every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks = n_checks + 1;
            if ({level, press, rel, lng} !== {m.level, m.press, m.rel, m.lng})
                $display("FAIL model_al0 t=%0t got=%b want=%b", $time,
                         {level, press, rel, lng}, {m.level, m.press, m.rel, m.lng});
            else n_pass = n_pass + 1;
            n_checks = n_checks + 1;
            if ({level_al, press_al, rel_al, lng_al} !== {m.level, m.press, m.rel, m.lng})
                $display("FAIL model_al1 t=%0t got=%b want=%b", $time,
                         {level_al, press_al, rel_al, lng_al}, {m.level, m.press, m.rel, m.lng});
            else n_pass = n_pass + 1;
        end
    end

    task automatic set_btn(input logic b);
        btn   = b;
        btn_n = ~b;
    endtask

    task automatic test_reset;
        int hits;
        hits = 0;
        set_btn(1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({level, press, rel, lng, level_al, press_al, rel_al, lng_al} != 8'b0)
                hits++;
        end
        n_checks++;
        if (hits !== 0) $display("FAIL idle_outputs got=%0d want=0", hits);
        else n_pass++;
    endtask

    task automatic test_press;
        int p_idx, p_cnt, l_idx, l_cnt;
        p_idx = -1; p_cnt = 0; l_idx = -1; l_cnt = 0;
        set_btn(1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (press) begin p_cnt++; if (p_idx < 0) p_idx = i; end
            if (lng)   begin l_cnt++; if (l_idx < 0) l_idx = i; end
        end
        n_checks++;
        if (p_idx !== 6) $display("FAIL press_latency got=%0d want=6", p_idx); else n_pass++;
        n_checks++;
        if (p_cnt !== 1) $display("FAIL press_count got=%0d want=1", p_cnt); else n_pass++;
        n_checks++;
        if (l_idx !== 26) $display("FAIL long_latency got=%0d want=26", l_idx); else n_pass++;
        n_checks++;
        if (l_cnt !== 1) $display("FAIL long_count got=%0d want=1", l_cnt); else n_pass++;
        n_checks++;
        if (level !== 1'b1) $display("FAIL press_level got=%b want=1", level); else n_pass++;
    endtask

    task automatic test_release_bounce;
        int r_cnt, low_lvl, r_idx;
        r_cnt = 0; low_lvl = 0; r_idx = -1;
        set_btn(1'b0);
        repeat (3) @(negedge clk);
        set_btn(1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rel) r_cnt++;
            if (!level) low_lvl++;
        end
        n_checks++;
        if (r_cnt !== 0) $display("FAIL bounce_release got=%0d want=0", r_cnt); else n_pass++;
        n_checks++;
        if (low_lvl !== 0) $display("FAIL bounce_level got=%0d want=0", low_lvl); else n_pass++;
        set_btn(1'b0);
        r_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rel) begin r_cnt++; if (r_idx < 0) r_idx = i; end
        end
        n_checks++;
        if (r_idx !== 6) $display("FAIL release_latency got=%0d want=6", r_idx); else n_pass++;
        n_checks++;
        if (r_cnt !== 1 || level !== 1'b0)
            $display("FAIL release_once got=%0d/%b want=1/0", r_cnt, level);
        else n_pass++;
    endtask

    task automatic test_press_bounce;
        int hits;
        hits = 0;
        for (int r = 0; r < 5; r++) begin
            set_btn(1'b1);
            repeat (3) begin @(negedge clk); if (press || level) hits++; end
            set_btn(1'b0);
            repeat (2) begin @(negedge clk); if (press || level) hits++; end
        end
        repeat (10) begin @(negedge clk); if (press || level) hits++; end
        n_checks++;
        if (hits !== 0) $display("FAIL press_bounce got=%0d want=0", hits); else n_pass++;
    endtask

    task automatic test_reset_mid_press;
        int r_cnt, p_idx;
        r_cnt = 0; p_idx = -1;
        set_btn(1'b1);
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({level, press, rel, lng, level_al, press_al, rel_al, lng_al} !== 8'b0)
            $display("FAIL async_reset got=%b want=0", {level, press, rel, lng,
                     level_al, press_al, rel_al, lng_al});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rel || rel_al) r_cnt++;
            if (press && p_idx < 0) p_idx = i;
        end
        n_checks++;
        if (r_cnt !== 0) $display("FAIL reset_no_release got=%0d want=0", r_cnt); else n_pass++;
        n_checks++;
        if (p_idx !== 6) $display("FAIL reacquire_latency got=%0d want=6", p_idx); else n_pass++;
    endtask

    task automatic test_random;
        int len;
        for (int r = 0; r < 80; r++) begin
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 8);
            set_btn(logic'($urandom_range(0, 1)));
            repeat (len) @(negedge clk);
        end
        set_btn(1'b0);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_press();
        test_release_bounce();
        test_press_bounce();
        test_reset_mid_press();
        test_random();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
